// File: rtl/pllrstseq.sv
// pllrstseq: reset/lock sequencer for the board PLL.
// Pulses the PLL areset, waits for a continuously held lock and only then
// releases the system reset. On loss of lock or a lock timeout it re-asserts
// system reset and retries the PLL, keeping a sticky loss flag and a
// saturating timeout counter.
module pllrstseq #(
  parameter int unsigned AR_CYCLES     = 16,
  parameter int unsigned LOCK_TIMEOUT  = 120000,
  parameter int unsigned STABLE_CYCLES = 1200,
  parameter int unsigned CW            = 20,
  parameter int unsigned RETRY_W       = 8
) (
  input  logic               i_clk,
  input  logic               i_reset,
  input  logic               i_pll_locked,
  input  logic               i_clear,
  output logic               o_pll_areset,
  output logic               o_sys_reset,
  output logic               o_ready,
  output logic               o_lock_lost,
  output logic [RETRY_W-1:0] o_retries
);

  typedef enum logic [1:0] {
    PLL_RESET = 2'd0,
    WAIT_LOCK = 2'd1,
    STABLE    = 2'd2,
    RUN       = 2'd3
  } state_t;

  localparam logic [CW-1:0] AR_LAST     = CW'(AR_CYCLES - 1);
  localparam logic [CW-1:0] TIMEOUT_LAST = CW'(LOCK_TIMEOUT - 1);
  localparam logic [CW-1:0] STABLE_LAST = CW'(STABLE_CYCLES - 1);

  state_t        state;
  logic [CW-1:0] cnt;
  logic          sync1;
  logic          lk;
  logic          timeout_ev;
  logic          loss_ev;

  // Two-flop synchronizer for the asynchronous PLL locked signal.
  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      sync1 <= 1'b0;
      lk    <= 1'b0;
    end else begin
      sync1 <= i_pll_locked;
      lk    <= sync1;
    end
  end

  // Flag events: lock timeout in WAIT_LOCK, loss of lock while running.
  always_comb begin
    timeout_ev = 1'b0;
    loss_ev    = 1'b0;
    if (state == WAIT_LOCK && !lk && cnt == TIMEOUT_LAST) begin
      timeout_ev = 1'b1;
    end
    if (state == RUN && !lk) begin
      loss_ev = 1'b1;
    end
  end

  // Sequencer FSM; outputs are registered alongside the next state.
  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      state        <= PLL_RESET;
      cnt          <= '0;
      o_pll_areset <= 1'b1;
      o_sys_reset  <= 1'b1;
      o_ready      <= 1'b0;
    end else begin
      o_sys_reset <= 1'b1;
      o_ready     <= 1'b0;
      case (state)
        PLL_RESET: begin
          if (cnt == AR_LAST) begin
            cnt          <= '0;
            state        <= WAIT_LOCK;
            o_pll_areset <= 1'b0;
          end else begin
            cnt          <= cnt + CW'(1);
            o_pll_areset <= 1'b1;
          end
        end
        WAIT_LOCK: begin
          // lock seen this cycle beats a coincident timeout
          if (lk) begin
            cnt          <= '0;
            state        <= STABLE;
            o_pll_areset <= 1'b0;
          end else if (cnt == TIMEOUT_LAST) begin
            cnt          <= '0;
            state        <= PLL_RESET;
            o_pll_areset <= 1'b1;
          end else begin
            cnt          <= cnt + CW'(1);
            o_pll_areset <= 1'b0;
          end
        end
        STABLE: begin
          o_pll_areset <= 1'b0;
          if (!lk) begin
            cnt   <= '0;
            state <= WAIT_LOCK;
          end else if (cnt == STABLE_LAST) begin
            cnt         <= '0;
            state       <= RUN;
            o_sys_reset <= 1'b0;
            o_ready     <= 1'b1;
          end else begin
            cnt <= cnt + CW'(1);
          end
        end
        RUN: begin
          if (!lk) begin
            cnt          <= '0;
            state        <= PLL_RESET;
            o_pll_areset <= 1'b1;
          end else begin
            o_pll_areset <= 1'b0;
            o_sys_reset  <= 1'b0;
            o_ready      <= 1'b1;
          end
        end
        default: begin
          cnt          <= '0;
          state        <= PLL_RESET;
          o_pll_areset <= 1'b1;
        end
      endcase
    end
  end

  // Sticky loss flag and saturating retry counter; a set/increment beats i_clear.
  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      o_lock_lost <= 1'b0;
      o_retries   <= '0;
    end else begin
      if (loss_ev) begin
        o_lock_lost <= 1'b1;
      end else if (i_clear) begin
        o_lock_lost <= 1'b0;
      end
      if (timeout_ev) begin
        if (o_retries != '1) begin
          o_retries <= o_retries + RETRY_W'(1);
        end
      end else if (i_clear) begin
        o_retries <= '0;
      end
    end
  end

endmodule

// File: tb/tb_pllrstseq.sv
// Scoreboard bench for pllrstseq: the stimulus process schedules expected
// output vectors for given cycles; a monitor compares them on the falling edge.
module tb_pllrstseq;

  logic       clk = 1'b0;
  logic       i_reset = 1'b0;
  logic       i_pll_locked = 1'b0;
  logic       i_clear = 1'b0;
  logic       o_pll_areset;
  logic       o_sys_reset;
  logic       o_ready;
  logic       o_lock_lost;
  logic [2:0] o_retries;

  pllrstseq #(
    .AR_CYCLES(4),
    .LOCK_TIMEOUT(20),
    .STABLE_CYCLES(8),
    .CW(8),
    .RETRY_W(3)
  ) dut (
    .i_clk(clk),
    .i_reset(i_reset),
    .i_pll_locked(i_pll_locked),
    .i_clear(i_clear),
    .o_pll_areset(o_pll_areset),
    .o_sys_reset(o_sys_reset),
    .o_ready(o_ready),
    .o_lock_lost(o_lock_lost),
    .o_retries(o_retries)
  );

  always #5 clk = ~clk;

  int unsigned cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    int unsigned cyc;
    string       name;
    logic [6:0]  v;  // {areset, sys_reset, ready, lock_lost, retries[2:0]}
  } exp_t;

  exp_t q[$];
  int   vectors = 0;
  int   miscompares = 0;

  task automatic push(input int unsigned c, input string nm, input logic a,
                      input logic s, input logic r, input logic l,
                      input logic [2:0] rt);
    exp_t e;
    int   i;
    e.cyc  = c;
    e.name = nm;
    e.v    = {a, s, r, l, rt};
    if (c <= cyc) begin
      vectors++;
      miscompares++;
      $display("FAIL sched_%s: cycle %0d already reached (now %0d)", nm, c, cyc);
    end else begin
      i = 0;
      while (i < q.size() && q[i].cyc <= c) i++;
      q.insert(i, e);
    end
  endtask

  task automatic wait_to(input int unsigned c);
    while (cyc < c) @(negedge clk);
  endtask

  // Assert reset on this falling edge; returns the first cycle showing reset state.
  task automatic do_reset(output int unsigned r);
    push(cyc + 1, "reset", 1'b1, 1'b1, 1'b0, 1'b0, 3'd0);
    i_reset = 1'b1;
    @(negedge clk);
    i_reset = 1'b0;
    r = cyc;
  endtask

  // Monitor: compare every scheduled vector on its cycle.
  always @(negedge clk) begin
    exp_t       e;
    logic [6:0] act;
    act = {o_pll_areset, o_sys_reset, o_ready, o_lock_lost, o_retries};
    while (q.size() > 0 && q[0].cyc <= cyc) begin
      e = q.pop_front();
      vectors++;
      if (e.cyc != cyc) begin
        miscompares++;
        $display("FAIL %s: vector for cycle %0d not checked (now %0d)", e.name, e.cyc, cyc);
      end else if (act !== e.v) begin
        miscompares++;
        $display("FAIL %s @%0d: got areset/sys/ready/lost=%b retries=%0d, expected areset/sys/ready/lost=%b retries=%0d",
                 e.name, cyc, act[6:3], act[2:0], e.v[6:3], e.v[2:0]);
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: time limit reached at cycle %0d", cyc);
    $fatal(1, "watchdog");
  end

  initial begin
    int unsigned r, d, r3, r4, r5;
    @(negedge clk);

    // 1: clean lock after reset
    do_reset(r);
    push(r + 3,  "ar_last",   1, 1, 0, 0, 0);
    push(r + 4,  "ar_end",    0, 1, 0, 0, 0);
    wait_to(r + 6);
    i_pll_locked = 1'b1;
    push(r + 16, "stab_pre",  0, 1, 0, 0, 0);
    push(r + 17, "run",       0, 0, 1, 0, 0);

    // 4: lock drops in RUN, then relocks
    wait_to(r + 20);
    d = cyc;
    i_pll_locked = 1'b0;
    push(d + 2,  "run_hold",  0, 0, 1, 0, 0);
    push(d + 3,  "loss",      1, 1, 0, 1, 0);
    push(d + 6,  "loss_ar",   1, 1, 0, 1, 0);
    push(d + 7,  "loss_arend",0, 1, 0, 1, 0);
    wait_to(d + 8);
    i_pll_locked = 1'b1;
    push(d + 18, "relock_pre",0, 1, 0, 1, 0);
    push(d + 19, "relock",    0, 0, 1, 1, 0);

    // 3: one-cycle glitch during STABLE restarts the stable count
    wait_to(d + 22);
    i_pll_locked = 1'b0;
    do_reset(r);
    wait_to(r + 6);
    i_pll_locked = 1'b1;
    push(r + 17, "glitch_norun", 0, 1, 0, 0, 0);
    push(r + 20, "glitch_noar",  0, 1, 0, 0, 0);
    push(r + 23, "glitch_pre",   0, 1, 0, 0, 0);
    push(r + 24, "glitch_run",   0, 0, 1, 0, 0);
    wait_to(r + 12);
    i_pll_locked = 1'b0;
    wait_to(r + 13);
    i_pll_locked = 1'b1;

    // 2: no lock: timeouts every 24 cycles, retries saturate at 7
    wait_to(r + 26);
    i_pll_locked = 1'b0;
    do_reset(r);
    push(r + 23,  "to_pre",   0, 1, 0, 0, 0);
    push(r + 24,  "to_1",     1, 1, 0, 0, 1);
    push(r + 27,  "to_1_ar",  1, 1, 0, 0, 1);
    push(r + 28,  "to_1_end", 0, 1, 0, 0, 1);
    push(r + 48,  "to_2",     1, 1, 0, 0, 2);
    push(r + 72,  "to_3",     1, 1, 0, 0, 3);
    push(r + 168, "to_7",     1, 1, 0, 0, 7);
    push(r + 191, "to_7_pre", 0, 1, 0, 0, 7);
    push(r + 192, "to_sat",   1, 1, 0, 0, 7);

    // 5: i_clear behaviour
    wait_to(r + 194);
    do_reset(r);
    push(r + 119, "clr_pre",  0, 1, 0, 0, 4);
    push(r + 120, "clr_to",   1, 1, 0, 0, 5);
    wait_to(r + 119);
    i_clear = 1'b1;
    wait_to(r + 120);
    i_clear = 1'b0;
    wait_to(r + 121);
    i_pll_locked = 1'b1;
    push(r + 132, "clr_stab", 0, 1, 0, 0, 5);
    push(r + 133, "clr_run",  0, 0, 1, 0, 5);
    push(r + 137, "clr_hold", 0, 0, 1, 0, 5);
    push(r + 138, "clr_loss", 1, 1, 0, 1, 5);
    push(r + 140, "clr_both_pre", 1, 1, 0, 1, 5);
    push(r + 141, "clr_both", 1, 1, 0, 0, 0);
    push(r + 162, "clr_to1",  1, 1, 0, 0, 1);
    push(r + 258, "clr_to5",  1, 1, 0, 0, 5);
    push(r + 281, "clr_to5_pre", 0, 1, 0, 0, 5);
    push(r + 282, "clr_vs_to", 1, 1, 0, 0, 6);
    push(r + 283, "clr_after", 1, 1, 0, 0, 6);
    wait_to(r + 135);
    i_pll_locked = 1'b0;
    wait_to(r + 140);
    i_clear = 1'b1;
    wait_to(r + 141);
    i_clear = 1'b0;
    wait_to(r + 281);
    i_clear = 1'b1;
    wait_to(r + 282);
    i_clear = 1'b0;

    // 6: reset mid-STABLE and mid-RUN with lock held
    wait_to(r + 284);
    i_pll_locked = 1'b1;
    wait_to(r + 290);
    do_reset(r3);
    push(r3 + 8, "mid_stab", 0, 1, 0, 0, 0);
    wait_to(r3 + 8);
    do_reset(r4);
    push(r4 + 3,  "rs_ar",    1, 1, 0, 0, 0);
    push(r4 + 4,  "rs_arend", 0, 1, 0, 0, 0);
    push(r4 + 12, "rs_pre",   0, 1, 0, 0, 0);
    push(r4 + 13, "rs_run",   0, 0, 1, 0, 0);
    wait_to(r4 + 15);
    do_reset(r5);
    push(r5 + 12, "rr_pre",   0, 1, 0, 0, 0);
    push(r5 + 13, "rr_run",   0, 0, 1, 0, 0);
    wait_to(r5 + 16);

    if (q.size() != 0) begin
      vectors++;
      miscompares++;
      $display("FAIL leftover: %0d vectors unchecked, expected 0", q.size());
    end
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
